// File: rtl/rc_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// rc_add_sub_pkg
// Shared constants for the ripple-carry adder/subtractor datapath.
//   MODE_ADD / MODE_SUB : encodings of the SnA mode-select input.
//   RC_WIDTH_32 / RC_WIDTH_64 : the operand widths the ALU elaborates.
// -----------------------------------------------------------------------------
package rc_add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int RC_WIDTH_32 = 32;
    localparam int RC_WIDTH_64 = 64;

endpackage : rc_add_sub_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full-adder cell, the building block of the ripple carry chain.
// Ports:
//   a, b  : operand bits
//   ci    : carry in from the previous stage
//   s     : sum bit
//   co    : carry out to the next stage
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic prop_s;

    // Propagate term is shared between the sum and the carry.
    assign prop_s = a ^ b;
    assign s      = prop_s ^ ci;
    assign co     = (a & b) | (ci & prop_s);

endmodule : full_adder

// File: rtl/rc_add_sub.sv
// -----------------------------------------------------------------------------
// rc_add_sub
// Ripple-carry adder/subtractor with registered outputs, the integer
// add/subtract datapath of the ALU.
// Parameters:
//   WIDTH : operand/result width (32 or 64 in use, any value >= 2 elaborates)
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-low reset (clears Y and CO)
//   A   : first operand (minuend when subtracting)
//   B   : second operand (subtrahend when subtracting)
//   SnA : mode select, MODE_ADD = add, MODE_SUB = subtract
//   Y   : registered sum/difference modulo 2^WIDTH
//   CO  : registered carry out of the MSB stage (in subtract mode, 1 = no borrow)
// -----------------------------------------------------------------------------
module rc_add_sub
    import rc_add_sub_pkg::*;
#(
    parameter int WIDTH = RC_WIDTH_32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic [WIDTH-1:0] Y,
    output logic             CO
);

    logic [WIDTH-1:0] b_cond_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   carry_s;

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             co_d;
    logic             co_q;

    // Subtraction is A + ~B + 1: inverting B and injecting SnA as the
    // stage-0 carry turns the same chain into a two's-complement subtractor.
    assign b_cond_s   = B ^ {WIDTH{SnA}};
    assign carry_s[0] = SnA;

    // The carry deliberately ripples through every cell; no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (A[i]),
            .b  (b_cond_s[i]),
            .ci (carry_s[i]),
            .s  (sum_s[i]),
            .co (carry_s[i+1])
        );
    end

    // Next-state values for the output register.
    always_comb begin
        y_d  = sum_s;
        co_d = carry_s[WIDTH];
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            y_q  <= {WIDTH{1'b0}};
            co_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
        end
    end

    assign Y  = y_q;
    assign CO = co_q;

endmodule : rc_add_sub

// File: tb/tb_rc_add_sub.sv
// -----------------------------------------------------------------------------
// tb_rc_add_sub
// Self-checking bench for rc_add_sub at WIDTH = 32 and WIDTH = 64. Both
// instances share the clock and operands (the 32-bit one sees the low half).
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_rc_add_sub;
    import rc_add_sub_pkg::*;

    logic        CLK;
    logic        RST;
    logic [63:0] a_s;
    logic [63:0] b_s;
    logic        sna_s;
    logic [31:0] y32_s;
    logic        co32_s;
    logic [63:0] y64_s;
    logic        co64_s;

    int n_checks;
    int n_errors;

    rc_add_sub #(.WIDTH(32)) dut32 (
        .CLK (CLK),
        .RST (RST),
        .A   (a_s[31:0]),
        .B   (b_s[31:0]),
        .SnA (sna_s),
        .Y   (y32_s),
        .CO  (co32_s)
    );

    rc_add_sub #(.WIDTH(64)) dut64 (
        .CLK (CLK),
        .RST (RST),
        .A   (a_s),
        .B   (b_s),
        .SnA (sna_s),
        .Y   (y64_s),
        .CO  (co64_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: add is unsigned addition with the bit above the MSB as CO;
    // subtract is modular difference with CO = 1 when A >= B (no borrow).
    function automatic void ref32(input logic [31:0] a, input logic [31:0] b,
                                  input logic mode,
                                  output logic [31:0] y, output logic co);
        logic [32:0] wide;
        if (mode == MODE_ADD) begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[31:0];
            co   = wide[32];
        end else begin
            y  = a - b;
            co = (a >= b);
        end
    endfunction

    function automatic void ref64(input logic [63:0] a, input logic [63:0] b,
                                  input logic mode,
                                  output logic [63:0] y, output logic co);
        logic [64:0] wide;
        if (mode == MODE_ADD) begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[63:0];
            co   = wide[64];
        end else begin
            y  = a - b;
            co = (a >= b);
        end
    endfunction

    // Apply operands, then sample one time unit after the next rising edge.
    task automatic step(input logic [63:0] a, input logic [63:0] b, input logic mode);
        a_s   = a;
        b_s   = b;
        sna_s = mode;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        step(64'd5, 64'd20, MODE_ADD);
        step(64'd5, 64'd20, MODE_ADD);
        n_checks++;
        if (y32_s !== 32'd0 || co32_s !== 1'b0) begin
            n_errors++;
            $display("FAIL reset32: got Y=%h CO=%b, want Y=0 CO=0", y32_s, co32_s);
        end
        n_checks++;
        if (y64_s !== 64'd0 || co64_s !== 1'b0) begin
            n_errors++;
            $display("FAIL reset64: got Y=%h CO=%b, want Y=0 CO=0", y64_s, co64_s);
        end
        RST = 1'b1;
        step(64'd5, 64'd20, MODE_ADD);
        n_checks++;
        if (y32_s !== 32'd25 || co32_s !== 1'b0) begin
            n_errors++;
            $display("FAIL release32: got Y=%0d CO=%b, want Y=25 CO=0", y32_s, co32_s);
        end
        n_checks++;
        if (y64_s !== 64'd25 || co64_s !== 1'b0) begin
            n_errors++;
            $display("FAIL release64: got Y=%0d CO=%b, want Y=25 CO=0", y64_s, co64_s);
        end
        // Reset asserted mid-stream clears a nonzero result.
        RST = 1'b0;
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD);
        n_checks++;
        if (y32_s !== 32'd0 || co32_s !== 1'b0 || y64_s !== 64'd0 || co64_s !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_override: got Y32=%h CO32=%b Y64=%h CO64=%b, want all 0",
                     y32_s, co32_s, y64_s, co64_s);
        end
        RST = 1'b1;
    endtask

    task automatic test_directed_32();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic        tm [8];
        logic [31:0] ty [8];
        logic        tc [8];
        ta = '{32'd0, 32'd0, 32'd0, 32'd5, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'h8000_0000};
        tb = '{32'd0, 32'd1, 32'd1, 32'd20, 32'd2, 32'd2000, 32'd1, 32'h8000_0000};
        tm = '{MODE_SUB, MODE_ADD, MODE_SUB, MODE_SUB, MODE_ADD, MODE_SUB, MODE_ADD, MODE_SUB};
        ty = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd6, 32'hFFFF_F834, 32'd0, 32'd0};
        tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step({32'd0, ta[i]}, {32'd0, tb[i]}, tm[i]);
            n_checks++;
            if (y32_s !== ty[i] || co32_s !== tc[i]) begin
                n_errors++;
                $display("FAIL dir32[%0d]: got Y=%h CO=%b, want Y=%h CO=%b",
                         i, y32_s, co32_s, ty[i], tc[i]);
            end
        end
    endtask

    task automatic test_directed_64();
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic        tm [3];
        logic [63:0] ty [3];
        logic        tc [3];
        ta = '{64'd0, 64'd2199023255552, 64'd2199023255552};
        tb = '{64'd100, 64'd2393, 64'd2393};
        tm = '{MODE_SUB, MODE_SUB, MODE_ADD};
        ty = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd2199023253159, 64'd2199023257945};
        tc = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(ta[i], tb[i], tm[i]);
            n_checks++;
            if (y64_s !== ty[i] || co64_s !== tc[i]) begin
                n_errors++;
                $display("FAIL dir64[%0d]: got Y=%h CO=%b, want Y=%h CO=%b",
                         i, y64_s, co64_s, ty[i], tc[i]);
            end
        end
        // 64-bit all-ones + 1 wraps to zero with carry out.
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD);
        n_checks++;
        if (y64_s !== 64'd0 || co64_s !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap64: got Y=%h CO=%b, want Y=0 CO=1", y64_s, co64_s);
        end
    endtask

    task automatic test_hold();
        step(64'd7, 64'd3, MODE_SUB);
        // Changing inputs between edges must not disturb the registered output.
        a_s   = 64'd1000;
        b_s   = 64'd1;
        sna_s = MODE_ADD;
        #3;
        n_checks++;
        if (y32_s !== 32'd4 || co32_s !== 1'b1 || y64_s !== 64'd4 || co64_s !== 1'b1) begin
            n_errors++;
            $display("FAIL hold: got Y32=%0d CO32=%b Y64=%0d CO64=%b, want 4/1 4/1",
                     y32_s, co32_s, y64_s, co64_s);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        logic        m;
        logic [31:0] ey32;
        logic        ec32;
        logic [63:0] ey64;
        logic        ec64;
        int          bad32;
        int          bad64;
        bad32 = 0;
        bad64 = 0;
        for (int n = 0; n < 10000; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            m = 1'($urandom_range(1, 0));
            case ($urandom_range(7, 0))
                0: b = a;
                1: b = ~a;
                2: b = 64'($urandom_range(3, 0));
                3: a = 64'($urandom_range(3, 0));
                default: ;
            endcase
            ref32(a[31:0], b[31:0], m, ey32, ec32);
            ref64(a, b, m, ey64, ec64);
            step(a, b, m);
            n_checks++;
            if (y32_s !== ey32 || co32_s !== ec32) begin
                n_errors++;
                if (bad32 < 5)
                    $display("FAIL rand32[%0d]: A=%h B=%h SnA=%b got Y=%h CO=%b, want Y=%h CO=%b",
                             n, a[31:0], b[31:0], m, y32_s, co32_s, ey32, ec32);
                bad32++;
            end
            n_checks++;
            if (y64_s !== ey64 || co64_s !== ec64) begin
                n_errors++;
                if (bad64 < 5)
                    $display("FAIL rand64[%0d]: A=%h B=%h SnA=%b got Y=%h CO=%b, want Y=%h CO=%b",
                             n, a, b, m, y64_s, co64_s, ey64, ec64);
                bad64++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST   = 1'b0;
        a_s   = 64'd0;
        b_s   = 64'd0;
        sna_s = MODE_ADD;
        test_reset();
        test_directed_32();
        test_directed_64();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rc_add_sub
